countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have no parameters; all digit widths are fixed.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset rst, synchronous, active-high.
REQ-004 tick  input  1  one-cycle pulse, one per 1/100 s; counts only while running.
REQ-005 load  input  1  capture ld_* preset values.
REQ-006 start  input  1  begin or resume the countdown.
REQ-007 pause  input  1  freeze the countdown.
REQ-008 ld_cent  input  4  preset hundredths, BCD 0-9.
REQ-009 ld_dec  input  4  preset tenths, BCD 0-9.
REQ-010 ld_us  input  4  preset seconds units, 0-9.
REQ-011 ld_ds  input  3  preset seconds tens, 0-5.
REQ-012 ld_um  input  4  preset minutes units, 0-9.
REQ-013 ld_dm  input  3  preset minutes tens, 0-5.
REQ-014 cent, dec, us, ds, um, dm  output  4,4,4,3,4,3  current count, registered.
REQ-015 running  output  1  high in RUN state.
REQ-016 done  output  1  high in DONE state.
REQ-017 expired  output  1  one-cycle pulse on entry to DONE.
REQ-018 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-019 Control SHALL be a 4-state FSM: IDLE, RUN, PAUSED, DONE.
REQ-020 Per-cycle priority SHALL be rst > load > pause > start > tick.
REQ-021 A load is valid only if each 4-bit field is <=9 and each 3-bit field is <=5.
REQ-022 Valid load in IDLE, PAUSED or DONE: count <= ld_* next edge, state <= IDLE.
REQ-023 Invalid load: count and state unchanged; load_err high the next cycle for one cycle.
REQ-024 load in RUN SHALL be ignored; no load_err.
REQ-025 start in IDLE or PAUSED with count nonzero -> RUN next edge; with count zero -> stays put.
REQ-026 start in RUN or DONE SHALL be ignored.
REQ-027 pause in RUN -> PAUSED; a tick in the same cycle is dropped.
REQ-028 pause outside RUN SHALL be ignored.
REQ-029 tick in RUN SHALL decrement the count by 0.01 s on the next edge.
REQ-030 Borrow chain: a digit at 0 wraps and borrows from the next digit.
 - cent, dec, us, um wrap to 9.
 - ds wraps to 5.
 - dm is never borrowed from at 0, because RUN exits at zero.
REQ-031 The tick that brings the count to 00:00.00 SHALL also move state to DONE on the same edge.
REQ-032 expired SHALL be high exactly the cycle after that edge, i.e. the first cycle done=1.
REQ-033 tick outside RUN SHALL have no effect.
REQ-034 Maximum preset 59:59.99 SHALL count down through all 359999 steps without skipping a value.

Reset
REQ-035 On rst the next edge SHALL give:
 - all count digits = 0
 - state = IDLE
 - running = done = expired = load_err = 0
REQ-036 rst mid-RUN or during DONE SHALL discard the count; no expired pulse is generated.

Verification
REQ-037 Load 00:00.03, start, 3 ticks -> counts 02, 01, 00; done=1 and one expired pulse after the 3rd tick; running=0.
REQ-038 Load 10:00.00, start, 1 tick -> 09:59.99 (full borrow chain, ds=5).
REQ-039 Load 00:05.00, start, 2 ticks, pause with a simultaneous tick, 5 ticks, start, 1 tick -> 00:04.98 while paused, then 00:04.97.
REQ-040 load with ld_ds=6 or ld_cent=0xA -> load_err one-cycle pulse; count unchanged.
REQ-041 Load 00:00.00, start -> stays IDLE; no expired pulse.
REQ-042 load asserted during RUN -> ignored; assert rst mid-RUN -> all outputs 0 next edge; a later load of 01:00.00 -> accepted.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control, preset and display signals of the mm:ss.cc countdown timer.
// master drives the controls and presets; slave is the timer itself.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] ld_cent;
  logic [3:0] ld_dec;
  logic [3:0] ld_us;
  logic [2:0] ld_ds;
  logic [3:0] ld_um;
  logic [2:0] ld_dm;
  logic [3:0] cent;
  logic [3:0] dec;
  logic [3:0] us;
  logic [2:0] ds;
  logic [3:0] um;
  logic [2:0] dm;
  logic       running;
  logic       done;
  logic       expired;
  logic       load_err;

  modport master (
    output tick, load, start, pause,
    output ld_cent, ld_dec, ld_us, ld_ds, ld_um, ld_dm,
    input  cent, dec, us, ds, um, dm,
    input  running, done, expired, load_err
  );

  modport slave (
    input  tick, load, start, pause,
    input  ld_cent, ld_dec, ld_us, ld_ds, ld_um, ld_dm,
    output cent, dec, us, ds, um, dm,
    output running, done, expired, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer mm:ss.cc (max 59:59.99) with load/start/pause control.
// Count is one packed vector {dm, um, ds, us, dec, cent} decremented by a borrow chain.
module countdown_timer (
  input logic             clk,
  input logic             rst,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t      state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic        expired_q, expired_d;
  logic        load_err_q, load_err_d;
  logic [21:0] ld_vec;
  logic [21:0] cnt_dec;

  // Steps one BCD-style digit down; wraps to max and raises borrow at zero.
  function automatic logic [3:0] dec_digit(input logic [3:0] d, input logic [3:0] max,
                                           input logic bin, output logic bout);
    logic [3:0] r;
    r    = d;
    bout = 1'b0;
    if (bin) begin
      if (d == 4'd0) begin
        r    = max;
        bout = 1'b1;
      end else begin
        r = d - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [21:0] dec_count(input logic [21:0] c);
    logic [21:0] r;
    logic [3:0]  t;
    logic        b0, b1, b2, b3, b4, b5;
    r        = c;
    r[3:0]   = dec_digit(c[3:0], 4'd9, 1'b1, b0);
    r[7:4]   = dec_digit(c[7:4], 4'd9, b0, b1);
    r[11:8]  = dec_digit(c[11:8], 4'd9, b1, b2);
    t        = dec_digit({1'b0, c[14:12]}, 4'd5, b2, b3);
    r[14:12] = t[2:0];
    r[18:15] = dec_digit(c[18:15], 4'd9, b3, b4);
    // dm never sits at zero when borrowed from, so no wrap value is needed.
    t        = dec_digit({1'b0, c[21:19]}, 4'd5, b4, b5);
    r[21:19] = t[2:0];
    return r;
  endfunction

  function automatic logic ld_valid(input logic [21:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[14:12] <= 3'd5) && (v[18:15] <= 4'd9) && (v[21:19] <= 3'd5);
  endfunction

  assign ld_vec  = {bus.ld_dm, bus.ld_um, bus.ld_ds, bus.ld_us, bus.ld_dec, bus.ld_cent};
  assign cnt_dec = dec_count(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  // Priority load > pause > start > tick; a command that does not apply in
  // the current state falls through to the next one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;
    if (bus.load && (state_q != RUN)) begin
      if (ld_valid(ld_vec)) begin
        cnt_d   = ld_vec;
        state_d = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.pause && (state_q == RUN)) begin
      state_d = PAUSED;
    end else if (bus.start && ((state_q == IDLE) || (state_q == PAUSED))) begin
      if (cnt_q != '0) state_d = RUN;
    end else if (bus.tick && (state_q == RUN)) begin
      cnt_d = cnt_dec;
      if (cnt_dec == '0) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end
    end
  end

  assign bus.cent     = cnt_q[3:0];
  assign bus.dec      = cnt_q[7:4];
  assign bus.us       = cnt_q[11:8];
  assign bus.ds       = cnt_q[14:12];
  assign bus.um       = cnt_q[18:15];
  assign bus.dm       = cnt_q[21:19];
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.expired  = expired_q;
  assign bus.load_err = load_err_q;

endmodule
